pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Front-end PC generation stage: owns the fetch PC register and drives pc_if to the BTB.
//  Consumes the BTB prediction and the backend redirect, and issues fetch requests to
//  instruction memory. Each accepted fetch is reported to the IF/ID stage together with
//  its prediction.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset (must be 4-byte aligned)
//  XLEN      riscv_pkg::XLEN (32)  PC/address width, taken from the package, not overridable
// PORTS
//  clk             in   1     clock, rising edge
//  reset           in   1     synchronous, active-high reset
//  stall_if        in   1     backend hazard stall; holds the PC, suppresses requests
//  redirect_valid  in   1     EX-stage branch/jump resolution or mispredict redirect
//  redirect_pc     in   XLEN  redirect target
//  btb_hit_valid   in   1     BTB hit for the current pc_if
//  btb_target      in   XLEN  BTB predicted target
//  imem_req_ready  in   1     imem accepts the request this cycle
//  imem_req_valid  out  1     fetch request valid
//  imem_req_addr   out  XLEN  fetch address (= pc_if)
//  pc_if           out  XLEN  current fetch PC to the BTB
//  btb_lookup_en   out  1     BTB lookup enable (= imem_req_valid)
//  if_valid        out  1     fetch accepted this cycle (fire)
//  if_pc           out  XLEN  PC of the accepted fetch
//  if_pred_taken   out  1     accepted fetch was predicted taken
//  if_pred_target  out  XLEN  predicted next PC of the accepted fetch
//  fetch_fault     out  1     level: PC is misaligned, fetch halted
// BEHAVIOUR
//  - FSM states: BOOT, FETCH, FAULT. Reset gives state=BOOT, pc=RESET_PC.
//    All outputs are 0 during reset except pc_if/imem_req_addr = RESET_PC.
//  - BOOT: lasts exactly 1 cycle after reset deasserts; no request; then goes to FETCH.
//  - FETCH: imem_req_valid = !stall_if && !redirect_valid; addr = pc.
//  - fire = imem_req_valid && imem_req_ready; if_valid = fire (combinational);
//    if_pc = pc.
//  - Target alignment: tgt_ok = btb_hit_valid && (btb_target[1:0] == 2'b00).
//    A misaligned BTB target is treated as a miss.
//  - Next-PC priority, highest first:
//    1. reset
//    2. redirect_valid -> pc <= redirect_pc
//    3. fire -> pc <= tgt_ok ? btb_target : pc+4
//    4. otherwise pc holds
//  - Redirect from FETCH/BOOT/FAULT:
//    - redirect_pc[1:0] == 0 -> state FETCH; the first request is the next cycle.
//    - redirect_pc[1:0] != 0 -> state FAULT; pc <= redirect_pc.
//  - FAULT: no requests; fetch_fault = 1; exits only on an aligned redirect.
//  - On fire: if_pred_taken = tgt_ok; if_pred_target = tgt_ok ? btb_target : pc+4.
//  - Arithmetic: pc+4 is computed modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000).
//  - Request withdrawal: imem_req_valid may drop without a handshake (stall or redirect).
//    imem must not commit an unaccepted request.
//  - stall_if and !imem_req_ready both only hold pc; neither changes state.
//  - Reset mid-operation: on the next edge return to BOOT with pc = RESET_PC.
//    Any pending redirect is discarded.
//  - Redirect and a BTB hit in the same cycle: the redirect wins and there is no fire.
//    The BTB result is ignored.
// TESTING
//  1. Start-up: RESET_PC=0, ready=1, no hit.
//     -> 1 idle BOOT cycle, then addr 0x0, 0x4, 0x8 on consecutive cycles, if_valid=1 each.
//  2. BTB hit at pc 0x8 with target 0x40.
//     -> if_pred_taken=1, if_pred_target=0x40; next addr 0x40.
//     A hit with target 0x42 -> if_pred_taken=0; next addr 0xC.
//  3. imem_req_ready=0 for 3 cycles at 0x10, then stall_if=1 for 2 cycles.
//     -> addr held at 0x10, if_valid=0 throughout; fires once both are released.
//  4. redirect_valid=1 with redirect_pc 0x100, in the same cycle as hit/ready at 0x20.
//     -> imem_req_valid=0 that cycle; next addr 0x100.
//  5. Redirect to 0x102.
//     -> FAULT, fetch_fault=1, no requests for 5 cycles.
//     Then redirect to 0x200 -> fetch_fault=0, addr 0x200.
//  6. pc = 0xFFFF_FFFC, no hit, fire -> next addr 0x0.
//     Assert reset mid-fetch at 0x80 -> BOOT, then resume from RESET_PC.

Source files
------------

// File: rtl/pc_gen.sv
// Front-end PC generation stage: fetch PC register, BTB-steered next-PC
// selection, imem request handshake and IF/ID report of accepted fetches.

package riscv_pkg;
    localparam int unsigned XLEN = 32;
endpackage

module pc_gen #(
    parameter logic [riscv_pkg::XLEN-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall_if,
    input  logic                      redirect_valid,
    input  logic [riscv_pkg::XLEN-1:0] redirect_pc,
    input  logic                      btb_hit_valid,
    input  logic [riscv_pkg::XLEN-1:0] btb_target,
    input  logic                      imem_req_ready,
    output logic                      imem_req_valid,
    output logic [riscv_pkg::XLEN-1:0] imem_req_addr,
    output logic [riscv_pkg::XLEN-1:0] pc_if,
    output logic                      btb_lookup_en,
    output logic                      if_valid,
    output logic [riscv_pkg::XLEN-1:0] if_pc,
    output logic                      if_pred_taken,
    output logic [riscv_pkg::XLEN-1:0] if_pred_target,
    output logic                      fetch_fault
);
    localparam int unsigned XLEN = riscv_pkg::XLEN;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_FAULT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic            req_valid;
    logic            fire;
    logic            tgt_ok;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] pc_pred;

    // State and PC registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state / next-PC selection and all outputs
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        imem_req_valid = 1'b0;
        imem_req_addr  = pc_q;
        pc_if          = pc_q;
        btb_lookup_en  = 1'b0;
        if_valid       = 1'b0;
        if_pc          = '0;
        if_pred_taken  = 1'b0;
        if_pred_target = '0;
        fetch_fault    = 1'b0;

        // A misaligned BTB target is treated as a miss; pc+4 wraps naturally.
        tgt_ok  = btb_hit_valid && (btb_target[1:0] == 2'b00);
        pc_seq  = pc_q + PC_STEP;
        pc_pred = tgt_ok ? btb_target : pc_seq;

        req_valid = !reset && (state_q == S_FETCH) && !stall_if && !redirect_valid;
        fire      = req_valid && imem_req_ready;

        // Redirect outranks any fire; stall or !ready simply leave pc untouched.
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = (redirect_pc[1:0] == 2'b00) ? S_FETCH : S_FAULT;
        end else begin
            case (state_q)
                S_BOOT:  state_d = S_FETCH;
                S_FETCH: if (fire) pc_d = pc_pred;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_BOOT;
            endcase
        end

        if (reset) begin
            imem_req_addr = RESET_PC;
            pc_if         = RESET_PC;
        end else begin
            imem_req_valid = req_valid;
            btb_lookup_en  = req_valid;
            if_valid       = fire;
            fetch_fault    = (state_q == S_FAULT);
            if (fire) begin
                if_pc          = pc_q;
                if_pred_taken  = tgt_ok;
                if_pred_target = pc_pred;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: per-cycle vector records pushed into a
// scoreboard queue when driven and compared against the DUT mid-cycle.

module tb_pc_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        btb_hit_valid;
    logic [31:0] btb_target;
    logic        imem_req_ready;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic [31:0] pc_if;
    logic        btb_lookup_en;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_if       (stall_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .btb_hit_valid  (btb_hit_valid),
        .btb_target     (btb_target),
        .imem_req_ready (imem_req_ready),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .pc_if          (pc_if),
        .btb_lookup_en  (btb_lookup_en),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .fetch_fault    (fetch_fault)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        hit;
        logic [31:0] tgt;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic        e_taken;
        logic [31:0] e_ptgt;
        logic        e_fault;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(input string name, input logic rst, input logic stall,
                                input logic rv, input logic [31:0] rpc, input logic hit,
                                input logic [31:0] tgt, input logic rdy, input logic e_req,
                                input logic [31:0] e_addr, input logic e_ifv,
                                input logic e_taken, input logic [31:0] e_ptgt,
                                input logic e_fault);
        vec_t v;
        v.name = name; v.rst = rst; v.stall = stall; v.rv = rv; v.rpc = rpc;
        v.hit = hit; v.tgt = tgt; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr;
        v.e_ifv = e_ifv; v.e_taken = e_taken; v.e_ptgt = e_ptgt; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus (just after a rising edge), sample at the falling edge.
    task automatic apply(input vec_t v);
        vec_t e;
        reset          = v.rst;
        stall_if       = v.stall;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        btb_hit_valid  = v.hit;
        btb_target     = v.tgt;
        imem_req_ready = v.rdy;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.name, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, e.e_req});
        chk({e.name, ".lookup_en"}, {31'd0, btb_lookup_en}, {31'd0, e.e_req});
        chk({e.name, ".req_addr"}, imem_req_addr, e.e_addr);
        chk({e.name, ".pc_if"}, pc_if, e.e_addr);
        chk({e.name, ".if_valid"}, {31'd0, if_valid}, {31'd0, e.e_ifv});
        chk({e.name, ".fault"}, {31'd0, fetch_fault}, {31'd0, e.e_fault});
        if (e.e_ifv) begin
            chk({e.name, ".if_pc"}, if_pc, e.e_addr);
            chk({e.name, ".pred_taken"}, {31'd0, if_pred_taken}, {31'd0, e.e_taken});
            chk({e.name, ".pred_target"}, if_pred_target, e.e_ptgt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              name     rst st rv rpc           hit tgt           rdy req addr          ifv tk ptgt          flt
        tbl.push_back(mk("rst0",  1, 0, 0, 32'h0,        0,  32'h0,        1,  0,  32'h0,        0,  0, 32'h0,        0));
        tbl.push_back(mk("rst1",  1, 0, 0, 32'h0,        0,  32'h0,        1,  0,  32'h0,        0,  0, 32'h0,        0));
        tbl.push_back(mk("boot",  0, 0, 0, 32'h0,        0,  32'h0,        1,  0,  32'h0,        0,  0, 32'h0,        0));
        tbl.push_back(mk("f0",    0, 0, 0, 32'h0,        0,  32'h0,        1,  1,  32'h0,        1,  0, 32'h4,        0));
        tbl.push_back(mk("f4",    0, 0, 0, 32'h0,        0,  32'h0,        1,  1,  32'h4,        1,  0, 32'h8,        0));
        tbl.push_back(mk("hit8",  0, 0, 0, 32'h0,        1,  32'h40,       1,  1,  32'h8,        1,  1, 32'h40,       0));
        tbl.push_back(mk("mis40", 0, 0, 0, 32'h0,        1,  32'h42,       1,  1,  32'h40,       1,  0, 32'h44,       0));
        tbl.push_back(mk("rd10",  0, 0, 1, 32'h10,       0,  32'h0,        1,  0,  32'h44,       0,  0, 32'h0,        0));
        tbl.push_back(mk("nr1",   0, 0, 0, 32'h0,        0,  32'h0,        0,  1,  32'h10,       0,  0, 32'h0,        0));
        tbl.push_back(mk("nr2",   0, 0, 0, 32'h0,        0,  32'h0,        0,  1,  32'h10,       0,  0, 32'h0,        0));
        tbl.push_back(mk("nr3",   0, 0, 0, 32'h0,        0,  32'h0,        0,  1,  32'h10,       0,  0, 32'h0,        0));
        tbl.push_back(mk("st1",   0, 1, 0, 32'h0,        0,  32'h0,        1,  0,  32'h10,       0,  0, 32'h0,        0));
        tbl.push_back(mk("st2",   0, 1, 0, 32'h0,        1,  32'h80,       1,  0,  32'h10,       0,  0, 32'h0,        0));
        tbl.push_back(mk("rel",   0, 0, 0, 32'h0,        0,  32'h0,        1,  1,  32'h10,       1,  0, 32'h14,       0));
        tbl.push_back(mk("f14",   0, 0, 0, 32'h0,        0,  32'h0,        1,  1,  32'h14,       1,  0, 32'h18,       0));
        tbl.push_back(mk("f18",   0, 0, 0, 32'h0,        0,  32'h0,        1,  1,  32'h18,       1,  0, 32'h1C,       0));
        tbl.push_back(mk("f1c",   0, 0, 0, 32'h0,        0,  32'h0,        1,  1,  32'h1C,       1,  0, 32'h20,       0));
        tbl.push_back(mk("rdhit", 0, 0, 1, 32'h100,      1,  32'h60,       1,  0,  32'h20,       0,  0, 32'h0,        0));
        tbl.push_back(mk("f100",  0, 0, 0, 32'h0,        0,  32'h0,        1,  1,  32'h100,      1,  0, 32'h104,      0));
        tbl.push_back(mk("rd102", 0, 0, 1, 32'h102,      0,  32'h0,        1,  0,  32'h104,      0,  0, 32'h0,        0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk("flt",0, 0, 0, 32'h0,       1,  32'h40,       1,  0,  32'h102,      0,  0, 32'h0,        1));
        tbl.push_back(mk("rd200", 0, 0, 1, 32'h200,      0,  32'h0,        1,  0,  32'h102,      0,  0, 32'h0,        1));
        tbl.push_back(mk("f200",  0, 0, 0, 32'h0,        0,  32'h0,        1,  1,  32'h200,      1,  0, 32'h204,      0));
        tbl.push_back(mk("rdtop", 0, 0, 1, 32'hFFFF_FFFC,0,  32'h0,        1,  0,  32'h204,      0,  0, 32'h0,        0));
        tbl.push_back(mk("wrap",  0, 0, 0, 32'h0,        0,  32'h0,        1,  1,  32'hFFFF_FFFC,1,  0, 32'h0,        0));
        tbl.push_back(mk("f0w",   0, 0, 0, 32'h0,        0,  32'h0,        1,  1,  32'h0,        1,  0, 32'h4,        0));
        tbl.push_back(mk("rd80",  0, 0, 1, 32'h80,       0,  32'h0,        1,  0,  32'h4,        0,  0, 32'h0,        0));
        tbl.push_back(mk("f80",   0, 0, 0, 32'h0,        0,  32'h0,        1,  1,  32'h80,       1,  0, 32'h84,       0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        // Reset mid-fetch at 0x84 with a pending redirect: redirect discarded, BOOT, resume at RESET_PC.
        apply(mk("mrst",  1, 0, 1, 32'h300, 1, 32'h40, 1, 0, 32'h0, 0, 0, 32'h0, 0));
        apply(mk("mboot", 0, 0, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0, 0, 0, 32'h0, 0));
        apply(mk("mf0",   0, 0, 0, 32'h0,   0, 32'h0,  1, 1, 32'h0, 1, 0, 32'h4, 0));
        apply(mk("mf4",   0, 0, 0, 32'h0,   0, 32'h0,  1, 1, 32'h4, 1, 0, 32'h8, 0));

        // Misaligned redirect during BOOT, then reset while faulted, then aligned redirect from BOOT.
        apply(mk("r2",    1, 0, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0,   0, 0, 32'h0, 0));
        apply(mk("brd",   0, 0, 1, 32'h103, 0, 32'h0,  1, 0, 32'h0,   0, 0, 32'h0, 0));
        apply(mk("bflt",  0, 0, 0, 32'h0,   0, 32'h0,  1, 0, 32'h103, 0, 0, 32'h0, 1));
        apply(mk("frst",  1, 0, 0, 32'h0,   0, 32'h0,  1, 0, 32'h0,   0, 0, 32'h0, 0));
        apply(mk("fboot", 0, 0, 1, 32'h8,   0, 32'h0,  1, 0, 32'h0,   0, 0, 32'h0, 0));
        apply(mk("f8",    0, 0, 0, 32'h0,   1, 32'h20, 1, 1, 32'h8,   1, 1, 32'h20, 0));
        apply(mk("f20",   0, 0, 0, 32'h0,   0, 32'h0,  1, 1, 32'h20,  1, 0, 32'h24, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
